imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, sets memory address width (32 entries).
REQ-002 Parameter DATA_W, default 8, sets memory word width.
REQ-003 Parameter STARVE_LIMIT, default 3, is the number of consecutive denied core cycles before the core is forced to win.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous and active-high despite the suffix.
REQ-006 h_req  input  1  host access request.
REQ-007 h_we  input  1  host write enable; 1=write, 0=read; qualified by h_req.
REQ-008 h_addr  input  ADDR_W  host address.
REQ-009 h_wdata  input  DATA_W  host write data.
REQ-010 h_lock  input  1  host exclusive mode for program load; core is never granted while high.
REQ-011 c_req  input  1  core fetch (read-only) request.
REQ-012 c_addr  input  ADDR_W  core fetch address.
REQ-013 h_gnt  output  1  host access accepted this cycle.
REQ-014 c_gnt  output  1  core access accepted this cycle.
REQ-015 h_rvalid  output  1  h_rdata valid; exactly one cycle after a granted host read.
REQ-016 h_rdata  output  DATA_W  host read data.
REQ-017 c_rvalid  output  1  c_rdata valid; exactly one cycle after a granted core read.
REQ-018 c_rdata  output  DATA_W  core read data.
REQ-019 starved  output  1  high while the starvation counter equals STARVE_LIMIT.

Function
REQ-020 The block owns a 2^ADDR_W x DATA_W memory with one access per cycle.
REQ-021 h_gnt and c_gnt are combinational from requests and registered state, and are never high together.
REQ-022 Priority: if h_lock, host only; else if starved and c_req, core wins; else host wins when h_req; else core wins when c_req.
REQ-023 A granted access is performed at the same clock edge; a request not granted is retried by the requester (inputs held), with no queuing inside the block.
REQ-024 A granted host write updates memory at that edge; h_rvalid stays low for writes.
REQ-025 Read latency is one cycle: rvalid pulses high for one cycle with the registered word; rdata holds its last value otherwise.
REQ-026 Starvation counter (width covering STARVE_LIMIT): +1 each cycle c_req=1 and c_gnt=0 and h_lock=0; saturates at STARVE_LIMIT; clears on c_gnt or c_req=0 or h_lock=1.
REQ-027 Read-after-write: a core read granted the cycle after a host write to the same address returns the new data.
REQ-028 Back-to-back grants to the same requester are allowed every cycle; no bubble is inserted.
REQ-029 Addresses are ADDR_W bits; no out-of-range case exists.

Reset
REQ-030 While rst_n=1 at an edge: h_rvalid=0, c_rvalid=0, h_rdata=0, c_rdata=0, starvation counter=0, and no memory write occurs.
REQ-031 During reset cycles, h_gnt=0 and c_gnt=0 regardless of requests.
REQ-032 Memory contents are not cleared by reset; a reset mid-operation discards any pending rvalid.

Structure
REQ-033 A shared package holds the ADDR_W/DATA_W defaults and the opcode constants (LOAD 0x01 .. HALT 0x0A) shared with the accumulator core.
REQ-034 One sub-module, imem_arb_pick, implements the combinational priority and starvation decision; the memory and read registers stay in imem_arbiter.

Verification
REQ-035 Host writes 0x01,0x2A,0x0A at addresses 0..2 with h_lock=1 and c_req=1 -> c_gnt stays 0 and starved stays 0; readback gives 0x01,0x2A,0x0A.
REQ-036 h_req and c_req both high continuously, h_lock=0 -> host is granted 3 cycles, core on the 4th with starved=1, and the pattern repeats.
REQ-037 Host writes 0x55 to addr 7, then the core reads addr 7 in the next cycle -> c_rvalid=1 one cycle later with c_rdata=0x55.
REQ-038 Core alone reads addr 0..31 on consecutive cycles -> c_gnt is high every cycle and c_rvalid is high on 32 consecutive cycles with the correct data.
REQ-039 Assert rst_n for one cycle with a granted read outstanding -> no rvalid follows, the counter is 0, and previously written memory data is intact.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter and the accumulator core:
// default geometry, opcode encoding and a counter-width helper.
package imem_arbiter_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [7:0] {
    OP_LOAD  = 8'h01,
    OP_STORE = 8'h02,
    OP_ADD   = 8'h03,
    OP_SUB   = 8'h04,
    OP_AND   = 8'h05,
    OP_OR    = 8'h06,
    OP_XOR   = 8'h07,
    OP_JMP   = 8'h08,
    OP_JZ    = 8'h09,
    OP_HALT  = 8'h0A
  } opcode_e;

  // Bits needed to hold 0..limit inclusive.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/imem_arb_pick.sv
// Combinational grant decision between host and core, plus the next value of
// the core starvation counter.
module imem_arb_pick
  import imem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = cnt_width(STARVE_LIMIT)
) (
  input  logic             rst_n,
  input  logic             h_req,
  input  logic             h_lock,
  input  logic             c_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             h_gnt,
  output logic             c_gnt,
  output logic             starved,
  output logic [CNT_W-1:0] starve_cnt_nxt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  assign starved = (starve_cnt == LIMIT);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    h_gnt          = 1'b0;
    c_gnt          = 1'b0;
    starve_cnt_nxt = '0;

    // rst_n is active-high here: no grants while it is asserted.
    if (!rst_n) begin
      if (h_lock)                h_gnt = h_req;
      else if (starved && c_req) c_gnt = 1'b1;
      else if (h_req)            h_gnt = 1'b1;
      else if (c_req)            c_gnt = 1'b1;

      if (!h_lock && c_req && !c_gnt)
        starve_cnt_nxt = starved ? LIMIT : starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory shared by a host (program load/debug) and a
// fetching core, with host priority bounded by a core starvation limit.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  input  logic              h_lock,
  input  logic              c_req,
  input  logic [ADDR_W-1:0] c_addr,
  output logic              h_gnt,
  output logic              c_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              starved
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = cnt_width(STARVE_LIMIT);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_cnt_nxt;

  imem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .rst_n          (rst_n),
    .h_req          (h_req),
    .h_lock         (h_lock),
    .c_req          (c_req),
    .starve_cnt     (starve_cnt),
    .h_gnt          (h_gnt),
    .c_gnt          (c_gnt),
    .starved        (starved),
    .starve_cnt_nxt (starve_cnt_nxt)
  );

  // NOTE: the memory array has no reset; program contents must survive a reset.
  always_ff @(posedge clk) begin
    if (!rst_n && h_gnt && h_we)
      mem[h_addr] <= h_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      h_rvalid   <= 1'b0;
      h_rdata    <= '0;
      c_rvalid   <= 1'b0;
      c_rdata    <= '0;
      starve_cnt <= '0;
    end else begin
      h_rvalid   <= h_gnt && !h_we;
      c_rvalid   <= c_gnt;
      starve_cnt <= starve_cnt_nxt;
      if (h_gnt && !h_we) h_rdata <= mem[h_addr];
      if (c_gnt)          c_rdata <= mem[c_addr];
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed and randomized checks of imem_arbiter against a cycle-level
// behavioural model of the arbitration, memory and read-return rules.
module tb_imem_arbiter;
  import imem_arbiter_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          h_req, h_we, h_lock, c_req;
  logic [AW-1:0] h_addr, c_addr;
  logic [DW-1:0] h_wdata;
  logic          h_gnt, c_gnt, h_rvalid, c_rvalid, starved;
  logic [DW-1:0] h_rdata, c_rdata;

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .h_req    (h_req),
    .h_we     (h_we),
    .h_addr   (h_addr),
    .h_wdata  (h_wdata),
    .h_lock   (h_lock),
    .c_req    (c_req),
    .c_addr   (c_addr),
    .h_gnt    (h_gnt),
    .c_gnt    (c_gnt),
    .h_rvalid (h_rvalid),
    .h_rdata  (h_rdata),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .starved  (starved)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: memory image, denied-streak length, expected read returns.
  logic [DW-1:0] m_mem [1 << AW];
  int            m_streak;
  logic          m_hv, m_cv;
  logic [DW-1:0] m_hd, m_cd;
  bit            known = 0;

  // Outputs observed at the start of the latest cycle (previous edge's result).
  logic          obs_hv, obs_cv;
  logic [DW-1:0] obs_hd, obs_cd;
  logic          obs_cgnt;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check grants,
  // then advance the model to the state after the coming rising edge.
  task automatic cycle(input logic r, input logic hq, input logic hw, input logic [AW-1:0] ha,
                       input logic [DW-1:0] hd, input logic hl, input logic cq,
                       input logic [AW-1:0] ca);
    logic eh, ec;
    @(negedge clk);
    obs_hv = h_rvalid; obs_hd = h_rdata;
    obs_cv = c_rvalid; obs_cd = c_rdata;
    if (known) begin
      chk("h_rvalid", {31'b0, obs_hv}, {31'b0, m_hv});
      chk("h_rdata",  {24'b0, obs_hd}, {24'b0, m_hd});
      chk("c_rvalid", {31'b0, obs_cv}, {31'b0, m_cv});
      chk("c_rdata",  {24'b0, obs_cd}, {24'b0, m_cd});
    end
    rst_n = r; h_req = hq; h_we = hw; h_addr = ha; h_wdata = hd;
    h_lock = hl; c_req = cq; c_addr = ca;
    #1;
    eh = 1'b0; ec = 1'b0;
    if (!r) begin
      if (hl)                         eh = hq;
      else if (m_streak == LIMIT && cq) ec = 1'b1;
      else if (hq)                    eh = 1'b1;
      else if (cq)                    ec = 1'b1;
    end
    obs_cgnt = c_gnt;
    chk("h_gnt", {31'b0, h_gnt}, {31'b0, eh});
    chk("c_gnt", {31'b0, c_gnt}, {31'b0, ec});
    if (known && !r)
      chk("starved", {31'b0, starved}, {31'b0, (m_streak == LIMIT)});
    if (r) begin
      m_hv = 0; m_cv = 0; m_hd = '0; m_cd = '0; m_streak = 0;
      known = 1;
    end else begin
      m_hv = eh && !hw;
      if (m_hv) m_hd = m_mem[ha];
      m_cv = ec;
      if (ec) m_cd = m_mem[ca];
      if (eh && hw) m_mem[ha] = hd;
      if (!hl && cq && !ec) m_streak = (m_streak < LIMIT) ? m_streak + 1 : LIMIT;
      else                  m_streak = 0;
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, '0, '0, 0, 0, '0);
  endtask

  initial begin
    int cv_count;
    m_streak = 0; m_hv = 0; m_cv = 0; m_hd = '0; m_cd = '0;

    // Reset with both requesters active: no grants, registers cleared.
    cycle(1, 1, 0, 5'd3, 8'h00, 0, 1, 5'd4);
    cycle(1, 1, 1, 5'd3, 8'hFF, 0, 1, 5'd4);
    idle();
    chk("rst_h_rvalid", {31'b0, obs_hv}, 32'd0);
    chk("rst_c_rdata",  {24'b0, obs_cd}, 32'd0);

    // Program load of the whole memory under lock.
    for (int a = 0; a < (1 << AW); a++)
      cycle(0, 1, 1, AW'(a), DW'($urandom), 1, 0, '0);

    // Locked load of a short program while the core keeps requesting.
    cycle(0, 1, 1, 5'd0, OP_LOAD, 1, 1, 5'd0);
    chk("lock_cgnt0", {31'b0, obs_cgnt}, 32'd0);
    cycle(0, 1, 1, 5'd1, 8'h2A,   1, 1, 5'd0);
    cycle(0, 1, 1, 5'd2, OP_HALT, 1, 1, 5'd0);
    chk("lock_cgnt2", {31'b0, obs_cgnt}, 32'd0);
    cycle(0, 1, 0, 5'd0, '0, 1, 1, 5'd0);
    chk("lock_starved", {31'b0, starved}, 32'd0);
    cycle(0, 1, 0, 5'd1, '0, 1, 1, 5'd0);
    chk("rb0", {24'b0, obs_hd}, 32'h01);
    cycle(0, 1, 0, 5'd2, '0, 1, 0, 5'd0);
    chk("rb1", {24'b0, obs_hd}, 32'h2A);
    idle();
    chk("rb2", {24'b0, obs_hd}, 32'h0A);

    // Host write immediately followed by a core read of the same address.
    cycle(0, 1, 1, 5'd7, 8'h55, 0, 0, '0);
    cycle(0, 0, 0, '0, '0, 0, 1, 5'd7);
    idle();
    chk("raw_valid", {31'b0, obs_cv}, 32'd1);
    chk("raw_data",  {24'b0, obs_cd}, 32'h55);

    // Continuous contention: host, host, host, core, repeating.
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1, 0, AW'(i), '0, 0, 1, AW'(i + 8));
      chk("contend_cgnt", {31'b0, obs_cgnt}, {31'b0, (i % 4 == 3)});
    end
    idle();

    // Core streams through every address with no bubbles.
    cv_count = 0;
    for (int a = 0; a <= (1 << AW); a++) begin
      if (a < (1 << AW)) cycle(0, 0, 0, '0, '0, 0, 1, AW'(a));
      else               idle();
      if (a > 0 && obs_cv) cv_count++;
    end
    chk("stream_rvalid_count", 32'(cv_count), 32'd32);

    // Reset with a core read outstanding; memory must survive.
    cycle(0, 0, 0, '0, '0, 0, 1, 5'd7);
    cycle(1, 0, 0, '0, '0, 0, 1, 5'd7);
    idle();
    chk("mid_rst_c_rvalid", {31'b0, obs_cv}, 32'd0);
    chk("mid_rst_starved",  {31'b0, starved}, 32'd0);
    cycle(0, 0, 0, '0, '0, 0, 1, 5'd7);
    idle();
    chk("mid_rst_mem7", {24'b0, obs_cd}, 32'h55);

    // Randomized traffic, including occasional locks and resets.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom), AW'($urandom),
            DW'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom), AW'($urandom));
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
